hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core. It generates the fetch-stage controls (stall_en, flush),
//  the ID/EX bubble and the global freeze. It also generates the EX operand forwarding selects.
//  It sits beside the datapath: inputs come from the decode/execute/memory/writeback stage registers,

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline control logic.
package riscv_pkg;

    // Width of a register index.
    localparam int REG_AW = 5;

    // Hazard sequencer states.
    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_FLUSH   = 2'd1,
        HZ_MEMWAIT = 2'd2
    } hz_state_e;

    // EX operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // True when a writing stage targets a non-x0 register equal to rs.
    function automatic logic rd_hit(input logic we, input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for one EX operand: EX/MEM beats MEM/WB, x0 never forwards.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output fwd_sel_e          sel
);

    // Youngest producer wins, so check the memory stage first.
    always_comb begin
        sel = FWD_RF;
        if (rd_hit(mem_we, mem_rd, ex_rs)) begin
            sel = FWD_MEM;
        end else if (rd_hit(wb_we, wb_rd, ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: fetch stall/flush, ID/EX bubble, global freeze,
// EX forwarding selects and stall/flush event counters.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CntW       = 32,
    parameter int FlushSlots = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_we_i,
    input  logic              jump_ok_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    output logic              stall_en_o,
    output logic              flush_o,
    output logic              idex_bubble_o,
    output logic              freeze_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CntW-1:0]   stall_cnt_o,
    output logic [CntW-1:0]   flush_cnt_o
);

    hz_state_e       state_reg, state_next;
    logic            pend_flush_reg, pend_flush_next;
    logic [CntW-1:0] stall_cnt_reg, flush_cnt_reg;

    logic stall_en, flush, idex_bubble, freeze, jump_acc;
    logic mem_wait, load_use;

    logic [REG_AW-1:0] ex_rs_arr [2];
    fwd_sel_e          fwd_sel_arr [2];

    assign ex_rs_arr[0] = ex_rs1_i;
    assign ex_rs_arr[1] = ex_rs2_i;

    // One independent forwarding compare per EX operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .ex_rs  (ex_rs_arr[gi]),
                .mem_rd (mem_rd_i),
                .mem_we (mem_we_i),
                .wb_rd  (wb_rd_i),
                .wb_we  (wb_we_i),
                .sel    (fwd_sel_arr[gi])
            );
        end
    endgenerate

    assign mem_wait = dmem_req_i && !dmem_ready_i;
    assign load_use = ex_is_load_i && (ex_rd_i != '0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Next state and controls; memory wait > jump > load-use.
    always_comb begin
        state_next      = state_reg;
        pend_flush_next = pend_flush_reg;
        stall_en        = 1'b0;
        flush           = 1'b0;
        idex_bubble     = 1'b0;
        freeze          = 1'b0;
        jump_acc        = 1'b0;
        if (mem_wait) begin
            // Everything holds; a flush slot interrupted here is replayed afterwards.
            stall_en   = 1'b1;
            freeze     = 1'b1;
            state_next = HZ_MEMWAIT;
            if (state_reg == HZ_FLUSH) begin
                pend_flush_next = 1'b1;
            end
        end else begin
            case (state_reg)
                HZ_RUN: begin
                    if (jump_ok_i) begin
                        // Fetch redirects itself, so no stall; squash IF/ID and ID/EX.
                        flush       = 1'b1;
                        idex_bubble = 1'b1;
                        jump_acc    = 1'b1;
                        state_next  = (FlushSlots == 2) ? HZ_FLUSH : HZ_RUN;
                    end else if (load_use) begin
                        stall_en    = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    // Second squashed slot; its jump_ok_i is meaningless.
                    idex_bubble = 1'b1;
                    stall_en    = load_use;
                    state_next  = HZ_RUN;
                end
                HZ_MEMWAIT: begin
                    // Ready cycle: release the freeze, resume any pending flush slot.
                    if (load_use) begin
                        stall_en    = 1'b1;
                        idex_bubble = 1'b1;
                    end
                    state_next      = pend_flush_reg ? HZ_FLUSH : HZ_RUN;
                    pend_flush_next = 1'b0;
                end
                default: begin
                    state_next      = HZ_RUN;
                    pend_flush_next = 1'b0;
                end
            endcase
        end
    end

    // State register and wrapping event counters.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg      <= HZ_RUN;
            pend_flush_reg <= 1'b0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            pend_flush_reg <= pend_flush_next;
            if (stall_en) begin
                stall_cnt_reg <= stall_cnt_reg + CntW'(1);
            end
            if (jump_acc) begin
                flush_cnt_reg <= flush_cnt_reg + CntW'(1);
            end
        end
    end

    // Controls are forced low while reset is held.
    assign stall_en_o    = rstn_i && stall_en;
    assign flush_o       = rstn_i && flush;
    assign idex_bubble_o = rstn_i && idex_bubble;
    assign freeze_o      = rstn_i && freeze;
    assign fwd_a_o       = rstn_i ? fwd_sel_arr[0] : FWD_RF;
    assign fwd_b_o       = rstn_i ? fwd_sel_arr[1] : FWD_RF;
    assign stall_cnt_o   = stall_cnt_reg;
    assign flush_cnt_o   = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CntW=32, FlushSlots=2).
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i, ex_rs1_i, ex_rs2_i, mem_rd_i, wb_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i, ex_is_load_i, mem_we_i, wb_we_i;
    logic        jump_ok_i, dmem_req_i, dmem_ready_i;
    logic        stall_en_o, flush_o, idex_bubble_o, freeze_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;
    logic [3:0]  ctl;

    int n_chk  = 0;
    int n_fail = 0;

    // {stall_en, flush, idex_bubble, freeze}
    assign ctl = {stall_en_o, flush_o, idex_bubble_o, freeze_o};

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.CntW(32), .FlushSlots(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
        .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
        .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i),
        .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i),
        .jump_ok_i(jump_ok_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .stall_en_o(stall_en_o), .flush_o(flush_o),
        .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1_i = '0; id_rs2_i = '0; id_use_rs1_i = 0; id_use_rs2_i = 0;
        ex_rd_i = '0; ex_is_load_i = 0; ex_rs1_i = '0; ex_rs2_i = '0;
        mem_rd_i = '0; mem_we_i = 0; wb_rd_i = '0; wb_we_i = 0;
        jump_ok_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
            jump_ok_i = 1; dmem_req_i = 1; mem_we_i = 1; mem_rd_i = 5'd7; ex_rs1_i = 5'd7;
            ex_is_load_i = 1; ex_rd_i = 5'd4; id_rs1_i = 5'd4; id_use_rs1_i = 1;
            #4;
            n_chk++;
            if (ctl !== 4'b0000 || fwd_a_o !== 2'd0) begin
                n_fail++; $display("FAIL rst_hold ctl=%b fwd_a=%0d want ctl=0000 fwd_a=0", ctl, fwd_a_o);
            end else $display("ok rst_hold cycle %0d", i);
        end
        n_chk++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL rst_cnt stall=%0d flush=%0d want 0/0", stall_cnt_o, flush_cnt_o);
        end else $display("ok rst_cnt");
        cyc();
        rstn_i = 1'b1;
        clear_inputs();
        #4;
        n_chk++;
        if (ctl !== 4'b0000 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL rst_release ctl=%b stall=%0d flush=%0d want 0000/0/0", ctl, stall_cnt_o, flush_cnt_o);
        end else $display("ok rst_release");
    endtask

    task automatic test_load_use();
        cyc();
        ex_is_load_i = 1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1;
        #4;
        n_chk++;
        if (ctl !== 4'b1010) begin
            n_fail++; $display("FAIL lu_rs1 ctl=%b want 1010", ctl);
        end else $display("ok lu_rs1");
        cyc();
        ex_is_load_i = 0;
        #4;
        n_chk++;
        if (ctl !== 4'b0000 || stall_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL lu_clear ctl=%b stall_cnt=%0d want 0000/1", ctl, stall_cnt_o);
        end else $display("ok lu_clear");
        cyc();
        ex_is_load_i = 1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_use_rs1_i = 1;
        #4;
        n_chk++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL lu_x0 ctl=%b want 0000", ctl);
        end else $display("ok lu_x0");
        cyc();
        ex_rd_i = 5'd9; id_rs1_i = 5'd0; id_use_rs1_i = 0; id_rs2_i = 5'd9; id_use_rs2_i = 1;
        #4;
        n_chk++;
        if (ctl !== 4'b1010) begin
            n_fail++; $display("FAIL lu_rs2 ctl=%b want 1010", ctl);
        end else $display("ok lu_rs2");
        cyc();
        id_use_rs2_i = 0;
        #4;
        n_chk++;
        if (ctl !== 4'b0000 || stall_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL lu_nouse ctl=%b stall_cnt=%0d want 0000/2", ctl, stall_cnt_o);
        end else $display("ok lu_nouse");
        cyc();
        clear_inputs();
    endtask

    task automatic test_jump();
        for (int hold = 1; hold <= 2; hold++) begin
            cyc();
            jump_ok_i = 1;
            #4;
            n_chk++;
            if (ctl !== 4'b0110) begin
                n_fail++; $display("FAIL jmp%0d_c0 ctl=%b want 0110", hold, ctl);
            end else $display("ok jmp%0d_c0", hold);
            cyc();
            jump_ok_i = (hold == 2);
            #4;
            n_chk++;
            if (ctl !== 4'b0010) begin
                n_fail++; $display("FAIL jmp%0d_c1 ctl=%b want 0010", hold, ctl);
            end else $display("ok jmp%0d_c1", hold);
            cyc();
            jump_ok_i = 0;
            #4;
            n_chk++;
            if (ctl !== 4'b0000 || flush_cnt_o !== 32'(hold) || stall_cnt_o !== 32'd2) begin
                n_fail++; $display("FAIL jmp%0d_c2 ctl=%b flush_cnt=%0d stall_cnt=%0d want 0000/%0d/2", hold, ctl, flush_cnt_o, stall_cnt_o, hold);
            end else $display("ok jmp%0d_c2", hold);
        end
    endtask

    task automatic test_memwait();
        for (int i = 0; i < 3; i++) begin
            cyc();
            dmem_req_i = 1; dmem_ready_i = 0; jump_ok_i = 1;
            ex_is_load_i = 1; ex_rd_i = 5'd6; id_rs1_i = 5'd6; id_use_rs1_i = 1;
            #4;
            n_chk++;
            if (ctl !== 4'b1001) begin
                n_fail++; $display("FAIL mw_wait%0d ctl=%b want 1001", i, ctl);
            end else $display("ok mw_wait%0d", i);
        end
        cyc();
        clear_inputs();
        dmem_req_i = 1; dmem_ready_i = 1;
        #4;
        n_chk++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL mw_ready ctl=%b want 0000", ctl);
        end else $display("ok mw_ready");
        cyc();
        clear_inputs();
        #4;
        n_chk++;
        if (ctl !== 4'b0000 || stall_cnt_o !== 32'd5 || flush_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL mw_after ctl=%b stall_cnt=%0d flush_cnt=%0d want 0000/5/2", ctl, stall_cnt_o, flush_cnt_o);
        end else $display("ok mw_after");
    endtask

    task automatic test_forward();
        cyc();
        mem_we_i = 1; mem_rd_i = 5'd7; wb_we_i = 1; wb_rd_i = 5'd7; ex_rs1_i = 5'd7; ex_rs2_i = 5'd7;
        #1;
        n_chk++;
        if (fwd_a_o !== 2'd1 || fwd_b_o !== 2'd1) begin
            n_fail++; $display("FAIL fwd_mem a=%0d b=%0d want 1/1", fwd_a_o, fwd_b_o);
        end else $display("ok fwd_mem");
        mem_we_i = 0;
        #1;
        n_chk++;
        if (fwd_a_o !== 2'd2 || fwd_b_o !== 2'd2) begin
            n_fail++; $display("FAIL fwd_wb a=%0d b=%0d want 2/2", fwd_a_o, fwd_b_o);
        end else $display("ok fwd_wb");
        mem_we_i = 1; mem_rd_i = 5'd0; wb_rd_i = 5'd0; ex_rs1_i = 5'd0; ex_rs2_i = 5'd0;
        #1;
        n_chk++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            n_fail++; $display("FAIL fwd_x0 a=%0d b=%0d want 0/0", fwd_a_o, fwd_b_o);
        end else $display("ok fwd_x0");
        ex_rs1_i = 5'd7; ex_rs2_i = 5'd3; wb_rd_i = 5'd3;
        #1;
        n_chk++;
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd2) begin
            n_fail++; $display("FAIL fwd_split a=%0d b=%0d want 0/2", fwd_a_o, fwd_b_o);
        end else $display("ok fwd_split");
        clear_inputs();
    endtask

    task automatic test_jump_memwait();
        logic [3:0] exp_ctl [6];
        exp_ctl = '{4'b0110, 4'b1001, 4'b1001, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            cyc();
            clear_inputs();
            jump_ok_i = (i == 0);
            dmem_req_i = (i >= 1 && i <= 3);
            dmem_ready_i = (i == 3);
            #4;
            n_chk++;
            if (ctl !== exp_ctl[i]) begin
                n_fail++; $display("FAIL jmw_c%0d ctl=%b want %b", i, ctl, exp_ctl[i]);
            end else $display("ok jmw_c%0d", i);
        end
        n_chk++;
        if (stall_cnt_o !== 32'd7 || flush_cnt_o !== 32'd3) begin
            n_fail++; $display("FAIL jmw_cnt stall=%0d flush=%0d want 7/3", stall_cnt_o, flush_cnt_o);
        end else $display("ok jmw_cnt");
        // Reset while in MEMWAIT.
        cyc();
        dmem_req_i = 1; dmem_ready_i = 0;
        cyc();
        rstn_i = 0;
        #1;
        n_chk++;
        if (ctl !== 4'b0000) begin
            n_fail++; $display("FAIL mw_rst_now ctl=%b want 0000", ctl);
        end else $display("ok mw_rst_now");
        cyc();
        rstn_i = 1;
        clear_inputs();
        jump_ok_i = 1;
        #4;
        n_chk++;
        if (ctl !== 4'b0110 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL mw_rst_run ctl=%b stall=%0d flush=%0d want 0110/0/0", ctl, stall_cnt_o, flush_cnt_o);
        end else $display("ok mw_rst_run");
        cyc();
        jump_ok_i = 0;
        #4;
        n_chk++;
        if (ctl !== 4'b0010 || flush_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL mw_rst_jmp ctl=%b flush=%0d want 0010/1", ctl, flush_cnt_o);
        end else $display("ok mw_rst_jmp");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jump();
        test_memwait();
        test_forward();
        test_jump_memwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
